// File: rtl/pipe_pkg.sv
// Shared encodings, field widths and bubble-entry values for the write-back stage.
package pipe_pkg;

   localparam int unsigned STAT_W  = 4;
   localparam int unsigned ICODE_W = 4;
   localparam int unsigned REG_W   = 4;
   localparam int unsigned PERF_W  = 32;

   localparam logic [STAT_W-1:0]  AOK   = STAT_W'(4'h1);
   localparam logic [ICODE_W-1:0] NOP   = ICODE_W'(4'h1);
   localparam logic [REG_W-1:0]   RNONE = REG_W'(4'hF);

   // Control fields carried alongside the data words in every slot
   typedef struct packed {
      logic [STAT_W-1:0]  stat;
      logic [ICODE_W-1:0] icode;
      logic [REG_W-1:0]   dst_e;
      logic [REG_W-1:0]   dst_m;
   } wb_ctrl_t;

   // Bubble entry control fields; data words of a bubble are all zero
   localparam wb_ctrl_t BUBBLE_CTRL = '{stat: AOK, icode: NOP, dst_e: RNONE, dst_m: RNONE};

   // An entry counts as a retired instruction when it is real work with a clean status
   function automatic logic is_retire(input wb_ctrl_t c);
      return (c.icode != NOP) && (c.stat == AOK);
   endfunction

endpackage

// File: rtl/pipe_wb_slot.sv
// One write-back pipeline register slot: reset/bubble to the bubble entry, load, or hold.
module pipe_wb_slot
   import pipe_pkg::*;
#(
   parameter int unsigned WORD_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_en,
   input  logic              bubble_sel,
   input  logic [WORD_W-1:0] nxt_val_e,
   input  logic [WORD_W-1:0] nxt_val_m,
   input  wb_ctrl_t          nxt_ctrl,
   output logic [WORD_W-1:0] cur_val_e,
   output logic [WORD_W-1:0] cur_val_m,
   output wb_ctrl_t          cur_ctrl
);

   // Slot register: reset and bubble both install the bubble entry; no load means hold
   always_ff @(posedge clock) begin
      if (reset) begin
         cur_val_e <= '0;
         cur_val_m <= '0;
         cur_ctrl  <= BUBBLE_CTRL;
      end else if (load_en) begin
         if (bubble_sel) begin
            cur_val_e <= '0;
            cur_val_m <= '0;
            cur_ctrl  <= BUBBLE_CTRL;
         end else begin
            cur_val_e <= nxt_val_e;
            cur_val_m <= nxt_val_m;
            cur_ctrl  <= nxt_ctrl;
         end
      end
   end

endmodule

// File: rtl/pipe_wb_reg.sv
// Write-back pipeline register: STAGES cascaded slots with stall, bubble and halt freeze.
// Optional performance counters are built when PIPE_WB_PERF_EN is defined.
module pipe_wb_reg
   import pipe_pkg::*;
#(
   parameter int unsigned WORD_W = 64,
   parameter int unsigned STAGES = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               W_stall,
   input  logic               W_bubble,
   input  logic [WORD_W-1:0]  m_valE,
   input  logic [WORD_W-1:0]  m_valM,
   input  logic [STAT_W-1:0]  m_stat,
   input  logic [ICODE_W-1:0] m_icode,
   input  logic [REG_W-1:0]   m_dstE,
   input  logic [REG_W-1:0]   m_dstM,
   output logic [WORD_W-1:0]  W_valE,
   output logic [WORD_W-1:0]  W_valM,
   output logic [STAT_W-1:0]  W_stat,
   output logic [ICODE_W-1:0] W_icode,
   output logic [REG_W-1:0]   W_dstE,
   output logic [REG_W-1:0]   W_dstM,
   output logic               W_halted
`ifdef PIPE_WB_PERF_EN
   ,
   output logic [PERF_W-1:0]  perf_instr,
   output logic [PERF_W-1:0]  perf_bubble
`endif
);

   logic [WORD_W-1:0] cur_val_e [STAGES];
   logic [WORD_W-1:0] cur_val_m [STAGES];
   wb_ctrl_t          cur_ctrl  [STAGES];
   wb_ctrl_t          m_ctrl;
   wb_ctrl_t          last_nxt_ctrl_c;
   logic              load_en_c;

   assign m_ctrl    = '{stat: m_stat, icode: m_icode, dst_e: m_dstE, dst_m: m_dstM};
   assign load_en_c = !W_halted && !W_stall;

   // Slot chain: slot 0 takes the memory stage (or a bubble), later slots shift
   for (genvar k = 0; k < int'(STAGES); k++) begin : g_slot
      if (k == 0) begin : g_head
         pipe_wb_slot #(.WORD_W(WORD_W)) u_slot (
            .clock      (clock),
            .reset      (reset),
            .load_en    (load_en_c),
            .bubble_sel (W_bubble),
            .nxt_val_e  (m_valE),
            .nxt_val_m  (m_valM),
            .nxt_ctrl   (m_ctrl),
            .cur_val_e  (cur_val_e[k]),
            .cur_val_m  (cur_val_m[k]),
            .cur_ctrl   (cur_ctrl[k])
         );
      end else begin : g_tail
         pipe_wb_slot #(.WORD_W(WORD_W)) u_slot (
            .clock      (clock),
            .reset      (reset),
            .load_en    (load_en_c),
            .bubble_sel (1'b0),
            .nxt_val_e  (cur_val_e[k-1]),
            .nxt_val_m  (cur_val_m[k-1]),
            .nxt_ctrl   (cur_ctrl[k-1]),
            .cur_val_e  (cur_val_e[k]),
            .cur_val_m  (cur_val_m[k]),
            .cur_ctrl   (cur_ctrl[k])
         );
      end
   end

   // Entry the final slot will take on a loading edge
   if (STAGES == 1) begin : g_last_single
      assign last_nxt_ctrl_c = W_bubble ? BUBBLE_CTRL : m_ctrl;
   end else begin : g_last_chain
      assign last_nxt_ctrl_c = cur_ctrl[STAGES-2];
   end

   assign W_valE  = cur_val_e[STAGES-1];
   assign W_valM  = cur_val_m[STAGES-1];
   assign W_stat  = cur_ctrl[STAGES-1].stat;
   assign W_icode = cur_ctrl[STAGES-1].icode;
   assign W_dstE  = cur_ctrl[STAGES-1].dst_e;
   assign W_dstM  = cur_ctrl[STAGES-1].dst_m;

   // Halt flag tracks the final slot's status; once set, load_en_c freezes it too
   always_ff @(posedge clock) begin
      if (reset) begin
         W_halted <= 1'b0;
      end else if (load_en_c) begin
         W_halted <= (last_nxt_ctrl_c.stat != AOK);
      end
   end

`ifdef PIPE_WB_PERF_EN
   // Retired-instruction and inserted-bubble counters, wrapping naturally
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_instr  <= '0;
         perf_bubble <= '0;
      end else if (load_en_c) begin
         if (is_retire(last_nxt_ctrl_c)) begin
            perf_instr <= perf_instr + PERF_W'(1);
         end
         if (W_bubble) begin
            perf_bubble <= perf_bubble + PERF_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_wb_reg.sv
// Directed bench for pipe_wb_reg: one-slot and three-slot instances share the stimulus.
module tb_pipe_wb_reg;

   logic        clock = 1'b0;
   logic        reset;
   logic        W_stall;
   logic        W_bubble;
   logic [63:0] m_valE;
   logic [63:0] m_valM;
   logic [3:0]  m_stat;
   logic [3:0]  m_icode;
   logic [3:0]  m_dstE;
   logic [3:0]  m_dstM;

   logic [63:0] a_valE, a_valM, b_valE, b_valM;
   logic [3:0]  a_stat, a_icode, a_dstE, a_dstM;
   logic [3:0]  b_stat, b_icode, b_dstE, b_dstM;
   logic        a_halted, b_halted;
`ifdef PIPE_WB_PERF_EN
   logic [31:0] a_pinstr, a_pbub, b_pinstr, b_pbub;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   pipe_wb_reg #(.WORD_W(64), .STAGES(1)) u1 (
      .clock(clock), .reset(reset), .W_stall(W_stall), .W_bubble(W_bubble),
      .m_valE(m_valE), .m_valM(m_valM), .m_stat(m_stat), .m_icode(m_icode),
      .m_dstE(m_dstE), .m_dstM(m_dstM),
      .W_valE(a_valE), .W_valM(a_valM), .W_stat(a_stat), .W_icode(a_icode),
      .W_dstE(a_dstE), .W_dstM(a_dstM), .W_halted(a_halted)
`ifdef PIPE_WB_PERF_EN
      , .perf_instr(a_pinstr), .perf_bubble(a_pbub)
`endif
   );

   pipe_wb_reg #(.WORD_W(64), .STAGES(3)) u3 (
      .clock(clock), .reset(reset), .W_stall(W_stall), .W_bubble(W_bubble),
      .m_valE(m_valE), .m_valM(m_valM), .m_stat(m_stat), .m_icode(m_icode),
      .m_dstE(m_dstE), .m_dstM(m_dstM),
      .W_valE(b_valE), .W_valM(b_valM), .W_stat(b_stat), .W_icode(b_icode),
      .W_dstE(b_dstE), .W_dstM(b_dstM), .W_halted(b_halted)
`ifdef PIPE_WB_PERF_EN
      , .perf_instr(b_pinstr), .perf_bubble(b_pbub)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_m(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] de,
                        input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
      m_stat = st; m_icode = ic; m_dstE = de; m_dstM = dm; m_valE = ve; m_valM = vm;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Full field check of the one-slot instance
   task automatic chk_a(input string tag, input logic [3:0] st, input logic [3:0] ic,
                        input logic [3:0] de, input logic [3:0] dm, input logic [63:0] ve,
                        input logic [63:0] vm, input logic h);
      chk({tag, ".a_stat"},  64'(a_stat),  64'(st));
      chk({tag, ".a_icode"}, 64'(a_icode), 64'(ic));
      chk({tag, ".a_dstE"},  64'(a_dstE),  64'(de));
      chk({tag, ".a_dstM"},  64'(a_dstM),  64'(dm));
      chk({tag, ".a_valE"},  a_valE, ve);
      chk({tag, ".a_valM"},  a_valM, vm);
      chk({tag, ".a_halted"}, 64'(a_halted), 64'(h));
   endtask

   // Full field check of the three-slot instance
   task automatic chk_b(input string tag, input logic [3:0] st, input logic [3:0] ic,
                        input logic [3:0] de, input logic [3:0] dm, input logic [63:0] ve,
                        input logic [63:0] vm, input logic h);
      chk({tag, ".b_stat"},  64'(b_stat),  64'(st));
      chk({tag, ".b_icode"}, 64'(b_icode), 64'(ic));
      chk({tag, ".b_dstE"},  64'(b_dstE),  64'(de));
      chk({tag, ".b_dstM"},  64'(b_dstM),  64'(dm));
      chk({tag, ".b_valE"},  b_valE, ve);
      chk({tag, ".b_valM"},  b_valM, vm);
      chk({tag, ".b_halted"}, 64'(b_halted), 64'(h));
   endtask

   initial begin
      // Reset wins over stall and bubble with live inputs
      reset = 1'b1; W_stall = 1'b1; W_bubble = 1'b1;
      set_m(4'h3, 4'h9, 4'h1, 4'h2, 64'hDEAD, 64'hBEEF);
      step();
      step();
      reset = 1'b0; W_stall = 1'b0; W_bubble = 1'b0;
      chk_a("reset", 4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
      chk_b("reset", 4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
`ifdef PIPE_WB_PERF_EN
      chk("reset.a_pinstr", 64'(a_pinstr), 64'h0);
      chk("reset.a_pbub",   64'(a_pbub),   64'h0);
`endif

      // Entry A: one-slot shows it after one edge, three-slot does not yet
      set_m(4'h1, 4'h6, 4'h2, 4'h3, 64'h5, 64'hABCD);
      step();
      chk_a("loadA", 4'h1, 4'h6, 4'h2, 4'h3, 64'h5, 64'hABCD, 1'b0);
      chk("loadA.b_valM", b_valM, 64'h0);
`ifdef PIPE_WB_PERF_EN
      chk("loadA.a_pinstr", 64'(a_pinstr), 64'h1);
`endif

      // Entry B
      set_m(4'h1, 4'h3, 4'h4, 4'hF, 64'h7, 64'h1111);
      step();
      chk("loadB.a_valE", a_valE, 64'h7);
      chk("loadB.b_valM", b_valM, 64'h0);

      // Entry C: A reaches the end of the three-slot chain
      set_m(4'h1, 4'h4, 4'h5, 4'h6, 64'h9, 64'h2222);
      step();
      chk("loadC.a_valE", a_valE, 64'h9);
      chk_b("loadC", 4'h1, 4'h6, 4'h2, 4'h3, 64'h5, 64'hABCD, 1'b0);

      // Stall three cycles with changing inputs, bubble raised in the middle cycle
      W_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         W_bubble = (i == 1);
         set_m(4'h1, 4'(4'h8 + i), 4'h7, 4'h8, 64'(64'h100 + i), 64'(64'h200 + i));
         step();
         chk_a("stall", 4'h1, 4'h4, 4'h5, 4'h6, 64'h9, 64'h2222, 1'b0);
         chk("stall.b_valM", b_valM, 64'hABCD);
`ifdef PIPE_WB_PERF_EN
         chk("stall.a_pbub", 64'(a_pbub), 64'h0);
`endif
      end
      W_stall = 1'b0; W_bubble = 1'b0;

      // Entry G: B reaches the three-slot output
      set_m(4'h1, 4'h5, 4'h1, 4'h1, 64'h10, 64'h3333);
      step();
      chk("loadG.a_valE", a_valE, 64'h10);
      chk_b("loadG", 4'h1, 4'h3, 4'h4, 4'hF, 64'h7, 64'h1111, 1'b0);

      // Bubble alone
      W_bubble = 1'b1;
      set_m(4'h1, 4'hA, 4'h2, 4'h2, 64'h77, 64'h88);
      step();
      W_bubble = 1'b0;
      chk_a("bubble", 4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
      chk("bubble.b_valE", b_valE, 64'h9);
      chk("bubble.b_icode", 64'(b_icode), 64'h4);
`ifdef PIPE_WB_PERF_EN
      chk("bubble.a_pbub", 64'(a_pbub), 64'h1);
`endif

      // Entry H loaded twice; the bubble then surfaces on the three-slot output
      set_m(4'h1, 4'h2, 4'h3, 4'h4, 64'h20, 64'h4444);
      step();
      chk("loadH.a_valE", a_valE, 64'h20);
      chk("loadH.b_valE", b_valE, 64'h10);
      step();
      chk_b("bubble3", 4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);

      // Halt status entry
      set_m(4'h2, 4'h0, 4'h5, 4'h6, 64'h30, 64'h5555);
      step();
      chk_a("halt", 4'h2, 4'h0, 4'h5, 4'h6, 64'h30, 64'h5555, 1'b1);
      chk("halt.b_valE", b_valE, 64'h20);
      chk("halt.b_halted", 64'(b_halted), 64'h0);

      // Further loads ignored by the halted one-slot instance
      set_m(4'h1, 4'h7, 4'h1, 4'h2, 64'h40, 64'h6666);
      step();
      chk_a("halted_ld", 4'h2, 4'h0, 4'h5, 4'h6, 64'h30, 64'h5555, 1'b1);
      chk("halted_ld.b_valE", b_valE, 64'h20);
      step();
      chk_b("halt3", 4'h2, 4'h0, 4'h5, 4'h6, 64'h30, 64'h5555, 1'b1);

      // Bubble and load while both halted
      W_bubble = 1'b1;
      step();
      W_bubble = 1'b0;
      step();
      chk_a("halted_bub", 4'h2, 4'h0, 4'h5, 4'h6, 64'h30, 64'h5555, 1'b1);
      chk_b("halted_bub", 4'h2, 4'h0, 4'h5, 4'h6, 64'h30, 64'h5555, 1'b1);
`ifdef PIPE_WB_PERF_EN
      chk("halted.a_pinstr", 64'(a_pinstr), 64'h6);
      chk("halted.a_pbub",   64'(a_pbub),   64'h1);
      chk("halted.b_pinstr", 64'(b_pinstr), 64'h6);
      chk("halted.b_pbub",   64'(b_pbub),   64'h1);
`endif

      // Reset releases the halt
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_a("rereset", 4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
      chk_b("rereset", 4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);

`ifdef PIPE_WB_PERF_EN
      // Counter wrap: preload at the top value, retire one more
      u1.perf_instr = 32'hFFFF_FFFF;
      set_m(4'h1, 4'h6, 4'h2, 4'h3, 64'h5, 64'hABCD);
      step();
      chk("wrap.a_pinstr", 64'(a_pinstr), 64'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
